xnor_serializer: RTL and testbench
==================================

# xnor_serializer

Upstream feeder for the bit-serial popcount accumulator in the BNN datapath. Accepts one N-bit activation vector and one N-bit weight vector per transaction over a valid/ready handshake. Forms their bitwise XNOR and streams it out one bit per cycle on `data_out`, with an active-low `put` qualifier that the accumulator consumes directly. Signals `last` on the final bit and pulses `done` once the vector is exhausted.

## Interface
- `N`, default 4: vector width, i.e. bits per transaction; N ≥ 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clock `clk`.
- `in_valid`  in  1  upstream offers `x_in`/`w_in`.
- `in_ready`  out  1  block can accept a vector.
- `x_in`  in  N  binary activation vector (1 = +1, 0 = −1).
- `w_in`  in  N  binary weight vector, same encoding.
- `data_out`  out  1  current XNOR bit; meaningful only while `put`=0.
- `put`  out  1  active-low bit-valid; 0 means the downstream accumulator adds `data_out` this cycle.
- `last`  out  1  high together with the final streamed bit.
- `done`  out  1  one-cycle pulse after the final bit.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Internal registers:
  - N-bit shift register `sr`.
  - Bit counter `cnt`, width $clog2(N+1).
  - 2-bit state: IDLE, SHIFT, DONE.
- All outputs decode from registers only; there is no combinational path from inputs to outputs.
- **IDLE**:
  - `in_ready`=1, `put`=1, `busy`=0.
  - On `in_valid`&`in_ready`: `sr` ← ~(x_in ^ w_in), `cnt` ← 0, go to SHIFT.
- **SHIFT**:
  - `put`=0, `busy`=1, `in_ready`=0.
  - `data_out` = `sr[0]`; `last` = (`cnt`==N−1).
  - Each edge: `sr` shifts right by one (zero fill) and `cnt` increments.
  - When `cnt`==N−1, go to DONE.
- **DONE**:
  - `put`=1, `done`=1, `in_ready`=0, `busy`=1.
  - Next edge: go to IDLE.
- `x_in`/`w_in` are sampled only on the accepting edge and ignored at all other times.
- `in_valid` asserted outside IDLE is not acknowledged. The upstream block holds it until `in_ready`.
- Reset values:
  - state = IDLE, `sr` = 0, `cnt` = 0.
  - `put`=1, `data_out`=0, `last`=0, `done`=0, `busy`=0, `in_ready`=1.
- Reset asserted mid-SHIFT aborts the vector immediately: `put` goes to 1 asynchronously and no further bits are emitted. Downstream partial sums are the accumulator's concern; it shares `rst`.
- N=1: SHIFT lasts exactly one cycle, with `last`=1 in that cycle.

## Timing
- Accept on edge k. Bits are presented in cycles k..k+N−1, i.e. after edges k..k+N−1, and the accumulator samples them on edges k+1..k+N.
- `last` is high in the cycle after edge k+N−1.
- `done` is high in the cycle after edge k+N.
- `in_ready` returns after edge k+N+1.
- Throughput: one vector per N+2 cycles. `put` deasserts for exactly 2 cycles (DONE plus the IDLE accept cycle) between back-to-back vectors.
- Accumulated result is valid in the downstream block on the edge at which `done` is sampled high.

## Configuration
- `XNOR_SER_MSB_FIRST_EN`
  - Defined: bits stream MSB first. `data_out` = `sr[N-1]` and the shift is left.
  - Undefined (default): LSB first, as described above.
- Counter, `last`, `done` and all timing are identical in both builds.

## Test plan
- N=4, x=1010, w=1100 (XNOR 1001): `data_out` 1,0,0,1 over 4 cycles with `put`=0; `last` on the 4th bit; `done` the next cycle; downstream accumulator reads 2.
- x=w=0110: four 1s; accumulator reads 4 (its maximum, 3 bits). x=0110, w=1001: four 0s; accumulator reads 0.
- Back-to-back vectors with `in_valid` held high:
  - Second accept occurs exactly 6 cycles after the first.
  - `put`=1 for exactly 2 cycles between the bursts.
  - `x_in` changes while the first vector is streaming do not affect its bits.
- `rst` pulsed after the 2nd bit: `put`=1, `in_ready`=1, `busy`=0 immediately. The next vector streams correctly from bit 0.
- With `XNOR_SER_MSB_FIRST_EN` defined, x=0000, w=0001 (XNOR 1110): stream is 1,1,1,0. Without the macro: 0,1,1,1. Accumulator reads 3 in both builds.
- N=1, x=1, w=1: one cycle of `put`=0 with `data_out`=1 and `last`=1, then `done`; accumulator reads 1.

Source files
------------

// File: rtl/xnor_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : xnor_serializer_if
//  Description : Handshake and serial-output bundle between the XNOR
//                serializer and its neighbours (upstream vector source on
//                the master side, serializer on the slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface xnor_serializer_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x_in;
  logic [N-1:0] w_in;
  logic         data_out;
  logic         put;
  logic         last;
  logic         done;
  logic         busy;

  // Upstream source / observer side
  modport master (
    output in_valid, x_in, w_in,
    input  in_ready, data_out, put, last, done, busy
  );

  // Serializer side
  modport slave (
    input  in_valid, x_in, w_in,
    output in_ready, data_out, put, last, done, busy
  );
endinterface
`default_nettype wire

// File: rtl/xnor_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : xnor_serializer
//  Description : Accepts an N-bit activation/weight pair, forms the bitwise
//                XNOR and streams it one bit per cycle with an active-low
//                put qualifier, a last flag and a done pulse.
//                Optional build macro: XNOR_SER_MSB_FIRST_EN
//                  defined   -> bits stream MSB first (left shift)
//                  undefined -> bits stream LSB first (right shift)
//  Revision    : 1.0 - initial release
// ============================================================================
module xnor_serializer #(
  parameter int N = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  xnor_serializer_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] c_last_cnt = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_sr;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_data_out;
  logic            r_put;
  logic            r_last;
  logic            r_done;
  logic            r_busy;

  logic [N-1:0]    w_xnor;
  logic [N-1:0]    w_sr_shift;
  logic            w_first_bit;
  logic            w_next_bit;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_accept;

  assign w_xnor    = ~(bus.x_in ^ bus.w_in);
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_accept  = bus.in_valid & r_in_ready;

`ifdef XNOR_SER_MSB_FIRST_EN
  assign w_sr_shift  = r_sr << 1;
  assign w_first_bit = w_xnor[N-1];
  assign w_next_bit  = w_sr_shift[N-1];
`else
  assign w_sr_shift  = r_sr >> 1;
  assign w_first_bit = w_xnor[0];
  assign w_next_bit  = w_sr_shift[0];
`endif

  // Control FSM plus datapath; every output is a register so the
  // downstream accumulator never sees a path from our inputs. The
  // presented bit is preloaded so data_out always equals the head of r_sr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b1;
      r_data_out <= 1'b0;
      r_put      <= 1'b1;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state    <= S_SHIFT;
            r_sr       <= w_xnor;
            r_cnt      <= '0;
            r_put      <= 1'b0;
            r_data_out <= w_first_bit;
            r_last     <= (c_last_cnt == '0);
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_sr  <= w_sr_shift;
          r_cnt <= w_cnt_inc;
          if (r_cnt == c_last_cnt) begin
            r_state    <= S_DONE;
            r_put      <= 1'b1;
            r_data_out <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_data_out <= w_next_bit;
            r_last     <= (w_cnt_inc == c_last_cnt);
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_put      <= 1'b1;
          r_data_out <= 1'b0;
          r_last     <= 1'b0;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.data_out = r_data_out;
  assign bus.put      = r_put;
  assign bus.last     = r_last;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_xnor_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xnor_serializer
//  Description : Scoreboard bench for xnor_serializer (N=4 main instance,
//                N=1 corner instance). Stream order follows
//                XNOR_SER_MSB_FIRST_EN exactly like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xnor_serializer;

  localparam int N   = 4;
  localparam int PER = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(PER/2) clk = ~clk;

  xnor_serializer_if #(.N(N)) bus ();
  xnor_serializer_if #(.N(1)) bus1 ();

  xnor_serializer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  xnor_serializer #(.N(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: expected bit stream and expected popcount per vector
  bit exp_bits[$];
  int exp_sum[$];
  int acc = 0;
  bit pending_done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: a bit is 1 where activation and weight agree
  function automatic void model_push(input logic [N-1:0] x, input logic [N-1:0] w);
    int s = 0;
    bit b;
    for (int k = 0; k < N; k++) begin
`ifdef XNOR_SER_MSB_FIRST_EN
      int i = N - 1 - k;
`else
      int i = k;
`endif
      b = (x[i] == w[i]);
      exp_bits.push_back(b);
      s += int'(b);
    end
    exp_sum.push_back(s);
  endfunction

  // Monitor: compares every cycle against the phase the scoreboard implies
  initial begin
    bit b;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_bits.size() > 0) begin
          check("shift_put", bus.put, 1'b0);
          check("shift_busy", bus.busy, 1'b1);
          check("shift_in_ready", bus.in_ready, 1'b0);
          check("shift_done", bus.done, 1'b0);
          b = exp_bits.pop_front();
          check("data_out", bus.data_out, b);
          check("last", bus.last, exp_bits.size() == 0);
          acc += int'(bus.data_out);
          if (exp_bits.size() == 0) pending_done = 1'b1;
        end else if (pending_done) begin
          check("done_pulse", bus.done, 1'b1);
          check("done_put", bus.put, 1'b1);
          check("done_busy", bus.busy, 1'b1);
          check("done_in_ready", bus.in_ready, 1'b0);
          check("popcount", acc, exp_sum.pop_front());
          acc = 0;
          pending_done = 1'b0;
        end else begin
          check("idle_put", bus.put, 1'b1);
          check("idle_done", bus.done, 1'b0);
          check("idle_busy", bus.busy, 1'b0);
          check("idle_in_ready", bus.in_ready, 1'b1);
        end
      end
    end
  end

  // Offer one vector starting at a negedge; returns at the negedge after
  // the accepting edge with in_valid still high. Inputs are scrambled
  // while waiting so held-off data cannot leak into the current stream.
  task automatic send(input logic [N-1:0] x, input logic [N-1:0] w, output time t_acc);
    int waited = 0;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 20) begin
      bus.x_in = N'($urandom);
      bus.w_in = N'($urandom);
      @(negedge clk);
      waited++;
    end
    check("accept_wait_bound", waited < 20, 1'b1);
    bus.x_in = x;
    bus.w_in = w;
    @(posedge clk);
    t_acc = $time;
    model_push(x, w);
    @(negedge clk);
  endtask

  initial begin
    time t_acc, t_prev;
    bit  chained;
    int  acc1;

    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.w_in      = '0;
    bus1.in_valid = 1'b0;
    bus1.x_in     = '0;
    bus1.w_in     = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_put", bus.put, 1'b1);
    check("rst_data_out", bus.data_out, 1'b0);
    check("rst_last", bus.last, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed vectors (popcounts 2, 4, 0, 3)
    send(4'b1010, 4'b1100, t_acc); bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    send(4'b0110, 4'b0110, t_acc); bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    send(4'b0110, 4'b1001, t_acc); bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    send(4'b0000, 4'b0001, t_acc); bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);

    // Back-to-back with in_valid held high
    send(4'b1010, 4'b1100, t_prev);
    send(4'b0011, 4'b0101, t_acc);
    check("b2b_spacing_1", int'((t_acc - t_prev) / PER), N + 2);
    t_prev = t_acc;
    send(4'b1111, 4'b0111, t_acc);
    check("b2b_spacing_2", int'((t_acc - t_prev) / PER), N + 2);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Abort mid-vector after two bits have been presented
    send(4'b1100, 4'b0101, t_acc);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_bits.delete();
    exp_sum.delete();
    acc = 0;
    pending_done = 1'b0;
    #1;
    check("abort_put", bus.put, 1'b1);
    check("abort_in_ready", bus.in_ready, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    send(4'b1001, 4'b0110, t_acc); bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);

    // Randomized traffic, randomly chained or gapped
    chained = 1'b0;
    t_prev  = 0;
    for (int i = 0; i < 30; i++) begin
      send(N'($urandom), N'($urandom), t_acc);
      if (chained) check("rand_b2b_spacing", int'((t_acc - t_prev) / PER), N + 2);
      t_prev  = t_acc;
      chained = 1'($urandom_range(0, 1));
      if (!chained) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 8)) @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("scoreboard_bits_drained", exp_bits.size(), 0);
    check("scoreboard_sums_drained", exp_sum.size(), 0);

    // N=1 corner: single-cycle stream
    acc1 = 0;
    check("n1_in_ready", bus1.in_ready, 1'b1);
    bus1.x_in     = 1'b1;
    bus1.w_in     = 1'b1;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check("n1_put", bus1.put, 1'b0);
    check("n1_data_out", bus1.data_out, 1'b1);
    check("n1_last", bus1.last, 1'b1);
    if (!bus1.put) acc1 += int'(bus1.data_out);
    @(negedge clk);
    check("n1_done", bus1.done, 1'b1);
    check("n1_done_put", bus1.put, 1'b1);
    check("n1_popcount", acc1, 1);
    @(negedge clk);
    check("n1_idle_done", bus1.done, 1'b0);
    check("n1_idle_in_ready", bus1.in_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
